// File: rtl/thread_sched_pkg.sv
// Shared types and sizes for the thread scheduler: thread state codes,
// FSM states, grant payload and index wrap helpers.
package thread_sched_pkg;

    localparam int unsigned N_THREADS   = 16;
    localparam int unsigned N_CORES     = 4;
    localparam int unsigned THREAD_W    = $clog2(N_THREADS);
    localparam int unsigned CORE_W      = $clog2(N_CORES);
    localparam int unsigned TS_W        = 2;
    localparam int unsigned WDOG_W      = 16;
    localparam int unsigned TIMEOUT_DEF = 4096;

    typedef enum logic [TS_W-1:0] {
        TS_NONE   = 2'd0,
        TS_WR_RDY = 2'd1,
        TS_BUSY   = 2'd2,
        TS_RD_RDY = 2'd3
    } thread_state_t;

    typedef enum logic [1:0] {
        ST_SCAN      = 2'd0,
        ST_GRANT     = 2'd1,
        ST_WAIT_DONE = 2'd2
    } sched_state_t;

    typedef struct packed {
        logic [THREAD_W-1:0] thread_num;
        logic [CORE_W-1:0]   core_num;
    } grant_t;

    // Thread index + 1 with wrap at N_THREADS-1.
    function automatic logic [THREAD_W-1:0] next_thread(input logic [THREAD_W-1:0] t);
        return (32'(t) == N_THREADS - 1) ? '0 : THREAD_W'(32'(t) + 32'd1);
    endfunction

    // Core index + 1 with wrap at N_CORES-1.
    function automatic logic [CORE_W-1:0] next_core(input logic [CORE_W-1:0] c);
        return (32'(c) == N_CORES - 1) ? '0 : CORE_W'(32'(c) + 32'd1);
    endfunction

endpackage

// File: rtl/thread_sched_if.sv
// Scheduler bus: thread_state read/write channel, core availability,
// and the start/done handshake with process_bytes.
interface thread_sched_if;
    import thread_sched_pkg::*;

    logic [THREAD_W-1:0] ts_rd_num;
    logic [TS_W-1:0]     ts_rd;
    logic [THREAD_W-1:0] ts_wr_num;
    logic                ts_wr_en;
    logic [TS_W-1:0]     ts_wr;
    logic [N_CORES-1:0]  core_ready;
    logic                start;
    logic [THREAD_W-1:0] thread_num;
    logic [CORE_W-1:0]   core_num;
    logic                done;
    logic                err;

    // Scheduler side.
    modport master (
        output ts_rd_num, ts_wr_num, ts_wr_en, ts_wr,
        output start, thread_num, core_num, err,
        input  ts_rd, core_ready, done
    );

    // Environment side (thread_state, cores, process_bytes).
    modport slave (
        input  ts_rd_num, ts_wr_num, ts_wr_en, ts_wr,
        input  start, thread_num, core_num, err,
        output ts_rd, core_ready, done
    );

endinterface

// File: rtl/thread_sched_rr_core_pick.sv
// Round-robin core selector: first ready core at or after cprio, wrapping.
module rr_core_pick
    import thread_sched_pkg::*;
(
    input  logic [N_CORES-1:0] core_ready,
    input  logic [CORE_W-1:0]  cprio,
    output logic [CORE_W-1:0]  core_num,
    output logic               any_ready
);

    logic        found;
    logic [31:0] idx;

    // Walk cores starting from cprio and keep the first ready one.
    always_comb begin
        core_num  = cprio;
        any_ready = |core_ready;
        found     = 1'b0;
        idx       = '0;
        for (int i = 0; i < N_CORES; i++) begin
            idx = (32'(cprio) + 32'(i)) % 32'(N_CORES);
            if (!found && core_ready[CORE_W'(idx)]) begin
                core_num = CORE_W'(idx);
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/thread_sched.sv
// Thread scheduler: round-robin scan of thread_state for WR_RDY threads,
// claims one when a core is free, issues start and waits for done.
// Optional watchdog on WAIT_DONE: define THREAD_SCHED_TIMEOUT_EN.
module thread_sched
    import thread_sched_pkg::*;
`ifdef THREAD_SCHED_TIMEOUT_EN
#(
    parameter int unsigned TIMEOUT = TIMEOUT_DEF
)
`endif
(
    input logic            CLK,
    input logic            RST,
    thread_sched_if.master bus
);

    sched_state_t        state;
    logic [THREAD_W-1:0] ptr;
    logic [THREAD_W-1:0] addr_d;
    logic                rd_vld;
    logic [CORE_W-1:0]   cprio;
    grant_t              held;
    logic                err_q;
    logic [CORE_W-1:0]   pick;
    logic                any_ready;
    logic                hit;
    logic                grant;
`ifdef THREAD_SCHED_TIMEOUT_EN
    logic [WDOG_W-1:0]   wdog;
`endif

    rr_core_pick u_pick (
        .core_ready (bus.core_ready),
        .cprio      (cprio),
        .core_num   (pick),
        .any_ready  (any_ready)
    );

    // A WR_RDY thread returned for the address registered last cycle.
    assign hit   = (state == ST_SCAN) && rd_vld && (bus.ts_rd == TS_WR_RDY) && any_ready;
    // Grant only if a core is still free in the GRANT cycle itself.
    assign grant = (state == ST_GRANT) && any_ready;

    // Grant outputs are qualified by live core_ready so a late drop cancels the claim.
    assign bus.ts_rd_num  = ptr;
    assign bus.ts_wr_num  = addr_d;
    assign bus.ts_wr      = TS_BUSY;
    assign bus.ts_wr_en   = grant;
    assign bus.start      = grant;
    assign bus.thread_num = grant ? addr_d : held.thread_num;
    assign bus.core_num   = grant ? pick   : held.core_num;
    assign bus.err        = err_q;

    // Scan pipeline, grant FSM, sticky error and optional watchdog.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state  <= ST_SCAN;
            ptr    <= '0;
            addr_d <= '0;
            rd_vld <= 1'b0;
            cprio  <= '0;
            held   <= '0;
            err_q  <= 1'b0;
`ifdef THREAD_SCHED_TIMEOUT_EN
            wdog   <= '0;
`endif
        end else begin
            if (bus.done && (state != ST_WAIT_DONE)) begin
                err_q <= 1'b1;
            end
            case (state)
                ST_SCAN: begin
                    if (hit) begin
                        // Freeze the scan; the read in flight is dropped.
                        state  <= ST_GRANT;
                        rd_vld <= 1'b0;
                    end else begin
                        addr_d <= ptr;
                        rd_vld <= 1'b1;
                        ptr    <= next_thread(ptr);
                    end
                end
                ST_GRANT: begin
                    if (any_ready) begin
                        state           <= ST_WAIT_DONE;
                        held.thread_num <= addr_d;
                        held.core_num   <= pick;
                        cprio           <= next_core(pick);
`ifdef THREAD_SCHED_TIMEOUT_EN
                        wdog            <= '0;
`endif
                    end else begin
                        // Cores vanished: rescan starting at the same thread.
                        state <= ST_SCAN;
                        ptr   <= addr_d;
                    end
                end
                ST_WAIT_DONE: begin
                    if (bus.done) begin
                        state <= ST_SCAN;
                        ptr   <= next_thread(held.thread_num);
                    end
`ifdef THREAD_SCHED_TIMEOUT_EN
                    else if (wdog == WDOG_W'(TIMEOUT - 1)) begin
                        // Abandon the thread (left BUSY) and resume scanning.
                        err_q <= 1'b1;
                        state <= ST_SCAN;
                        ptr   <= next_thread(held.thread_num);
                    end else begin
                        wdog <= wdog + WDOG_W'(1);
                    end
`endif
                end
                default: begin
                    state <= ST_SCAN;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_thread_sched.sv
// Self-checking bench for thread_sched: models thread_state memory, drives
// core_ready/done, and scoreboards expected grants against start pulses.
module tb_thread_sched;
    import thread_sched_pkg::*;

`ifdef THREAD_SCHED_TIMEOUT_EN
    localparam int unsigned TB_TIMEOUT = 64;
`endif

    logic CLK;
    logic RST;
    thread_sched_if bus ();

`ifdef THREAD_SCHED_TIMEOUT_EN
    thread_sched #(.TIMEOUT(TB_TIMEOUT)) dut (.CLK(CLK), .RST(RST), .bus(bus));
`else
    thread_sched dut (.CLK(CLK), .RST(RST), .bus(bus));
`endif

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int start_cnt = 0;
    int start_cyc = 0;
    int rel_cyc = 0;
    grant_t exp_q[$];
    grant_t g;

    logic [TS_W-1:0]     mem [N_THREADS];
    logic                cpu_we;
    logic                cpu_clr;
    logic [THREAD_W-1:0] cpu_num;
    logic [TS_W-1:0]     cpu_val;

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    // thread_state model: 1-cycle read latency, CPU and scheduler writes.
    always @(posedge CLK) begin
        if (cpu_clr) begin
            for (int i = 0; i < N_THREADS; i++) mem[i] <= TS_NONE;
        end else if (cpu_we) begin
            mem[cpu_num] <= cpu_val;
        end
        if (bus.ts_wr_en) mem[bus.ts_wr_num] <= bus.ts_wr;
        bus.ts_rd <= mem[bus.ts_rd_num];
    end

    // Advance one cycle, scoreboarding any start seen at the falling edge.
    task automatic step();
        @(negedge CLK);
        if (!RST) begin
            if (bus.start) begin
                start_cnt++;
                start_cyc = cyc;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_start thread=%0d core=%0d", bus.thread_num, bus.core_num);
                end else begin
                    g = exp_q.pop_front();
                    if ({bus.thread_num, bus.core_num} !== g) begin
                        errors++;
                        $display("FAIL grant thread=%0d core=%0d expected thread=%0d core=%0d",
                                 bus.thread_num, bus.core_num, g.thread_num, g.core_num);
                    end
                    checks++;
                    if (bus.ts_wr_en !== 1'b1 || bus.ts_wr_num !== g.thread_num || bus.ts_wr !== TS_BUSY) begin
                        errors++;
                        $display("FAIL ts_write en=%0b num=%0d val=%0d expected en=1 num=%0d val=%0d",
                                 bus.ts_wr_en, bus.ts_wr_num, bus.ts_wr, g.thread_num, TS_BUSY);
                    end
                end
            end else begin
                checks++;
                if (bus.ts_wr_en !== 1'b0) begin
                    errors++;
                    $display("FAIL stray_write en=%0b expected 0", bus.ts_wr_en);
                end
            end
        end
        #1;
    endtask

    task automatic steps(input int n);
        repeat (n) step();
    endtask

    task automatic reset_dut();
        RST = 1'b1;
        bus.done = 1'b0;
        cpu_clr = 1'b1;
        step();
        cpu_clr = 1'b0;
        step();
        exp_q.delete();
        start_cnt = 0;
    endtask

    task automatic release_rst();
        RST = 1'b0;
        rel_cyc = cyc;
    endtask

    task automatic set_state(input int n, input logic [TS_W-1:0] v);
        cpu_we = 1'b1;
        cpu_num = THREAD_W'(n);
        cpu_val = v;
        step();
        cpu_we = 1'b0;
    endtask

    task automatic pulse_done();
        bus.done = 1'b1;
        step();
        bus.done = 1'b0;
    endtask

    task automatic wait_starts(input int target, input int budget, input string name);
        int k;
        k = 0;
        while (start_cnt < target && k < budget) begin
            step();
            k++;
        end
        checks++;
        if (start_cnt < target) begin
            errors++;
            $display("FAIL %s start_count=%0d expected %0d within %0d cycles", name, start_cnt, target, budget);
        end
    endtask

    task automatic test_reset();
        RST = 1'b1;
        step();
        checks++; if (bus.ts_rd_num !== '0) begin errors++; $display("FAIL rst_ts_rd_num got=%0d exp=0", bus.ts_rd_num); end
        checks++; if (bus.ts_wr_en !== 1'b0) begin errors++; $display("FAIL rst_ts_wr_en got=%0b exp=0", bus.ts_wr_en); end
        checks++; if (bus.start !== 1'b0) begin errors++; $display("FAIL rst_start got=%0b exp=0", bus.start); end
        checks++; if (bus.thread_num !== '0) begin errors++; $display("FAIL rst_thread_num got=%0d exp=0", bus.thread_num); end
        checks++; if (bus.core_num !== '0) begin errors++; $display("FAIL rst_core_num got=%0d exp=0", bus.core_num); end
        checks++; if (bus.err !== 1'b0) begin errors++; $display("FAIL rst_err got=%0b exp=0", bus.err); end
    endtask

    task automatic test_idle_scan();
        reset_dut();
        bus.core_ready = 4'b1111;
        release_rst();
        for (int i = 0; i < 40; i++) begin
            checks++;
            if (bus.ts_rd_num !== THREAD_W'(i % N_THREADS)) begin
                errors++;
                $display("FAIL idle_scan step=%0d ts_rd_num=%0d exp=%0d", i, bus.ts_rd_num, i % N_THREADS);
            end
            step();
        end
        checks++;
        if (start_cnt != 0) begin errors++; $display("FAIL idle_no_start count=%0d exp=0", start_cnt); end
    endtask

    task automatic test_single_grant();
        reset_dut();
        bus.core_ready = 4'b0010;
        set_state(5, TS_WR_RDY);
        exp_q.push_back('{thread_num: 4'd5, core_num: 2'd1});
        release_rst();
        wait_starts(1, 30, "single_start");
        checks++;
        if (start_cyc != rel_cyc + 7) begin errors++; $display("FAIL single_latency cyc=%0d exp=%0d", start_cyc - rel_cyc, 7); end
        steps(20);
        checks++;
        if (start_cnt != 1) begin errors++; $display("FAIL single_no_regrant count=%0d exp=1", start_cnt); end
        checks++;
        if (mem[5] !== TS_BUSY) begin errors++; $display("FAIL single_busy state=%0d exp=%0d", mem[5], TS_BUSY); end
        pulse_done();
        checks++;
        if (bus.ts_rd_num !== 4'd6) begin errors++; $display("FAIL single_resume ts_rd_num=%0d exp=6", bus.ts_rd_num); end
        checks++;
        if (bus.err !== 1'b0) begin errors++; $display("FAIL single_err err=%0b exp=0", bus.err); end
    endtask

    task automatic test_two_grants();
        reset_dut();
        bus.core_ready = 4'b1111;
        set_state(3, TS_WR_RDY);
        set_state(9, TS_WR_RDY);
        exp_q.push_back('{thread_num: 4'd3, core_num: 2'd0});
        exp_q.push_back('{thread_num: 4'd9, core_num: 2'd1});
        release_rst();
        wait_starts(1, 30, "two_first");
        steps(10);
        checks++;
        if (start_cnt != 1) begin errors++; $display("FAIL two_hold count=%0d exp=1", start_cnt); end
        pulse_done();
        checks++;
        if (bus.ts_rd_num !== 4'd4) begin errors++; $display("FAIL two_resume1 ts_rd_num=%0d exp=4", bus.ts_rd_num); end
        wait_starts(2, 30, "two_second");
        steps(10);
        pulse_done();
        checks++;
        if (bus.ts_rd_num !== 4'd10) begin errors++; $display("FAIL two_resume2 ts_rd_num=%0d exp=10", bus.ts_rd_num); end
    endtask

    task automatic test_core_busy();
        reset_dut();
        bus.core_ready = 4'b0000;
        set_state(2, TS_WR_RDY);
        release_rst();
        steps(40);
        checks++;
        if (start_cnt != 0) begin errors++; $display("FAIL busy_no_grant count=%0d exp=0", start_cnt); end
        exp_q.push_back('{thread_num: 4'd2, core_num: 2'd3});
        bus.core_ready = 4'b1000;
        wait_starts(1, 2 + N_THREADS, "busy_late_grant");
        pulse_done();
    endtask

    task automatic test_retry();
        reset_dut();
        bus.core_ready = 4'b1111;
        set_state(4, TS_WR_RDY);
        release_rst();
        steps(5);
        @(posedge CLK);
        #1;
        bus.core_ready = 4'b0000;
        step();
        step();
        checks++;
        if (bus.ts_rd_num !== 4'd4) begin errors++; $display("FAIL retry_ptr ts_rd_num=%0d exp=4", bus.ts_rd_num); end
        checks++;
        if (start_cnt != 0) begin errors++; $display("FAIL retry_no_grant count=%0d exp=0", start_cnt); end
        exp_q.push_back('{thread_num: 4'd4, core_num: 2'd2});
        bus.core_ready = 4'b0100;
        wait_starts(1, 10, "retry_grant");
        checks++;
        if (start_cyc != rel_cyc + 9) begin errors++; $display("FAIL retry_latency cyc=%0d exp=9", start_cyc - rel_cyc); end
        pulse_done();
    endtask

    task automatic test_err();
        reset_dut();
        bus.core_ready = 4'b0000;
        release_rst();
        steps(3);
        checks++;
        if (bus.err !== 1'b0) begin errors++; $display("FAIL err_pre err=%0b exp=0", bus.err); end
        pulse_done();
        checks++;
        if (bus.err !== 1'b1) begin errors++; $display("FAIL err_set err=%0b exp=1", bus.err); end
        steps(5);
        checks++;
        if (bus.err !== 1'b1) begin errors++; $display("FAIL err_sticky err=%0b exp=1", bus.err); end
    endtask

    task automatic test_reset_mid();
        reset_dut();
        bus.core_ready = 4'b1111;
        set_state(6, TS_WR_RDY);
        exp_q.push_back('{thread_num: 4'd6, core_num: 2'd0});
        release_rst();
        pulse_done();
        wait_starts(1, 30, "mid_start");
        steps(3);
        checks++;
        if (bus.thread_num !== 4'd6 || bus.err !== 1'b1) begin
            errors++;
            $display("FAIL mid_pre thread=%0d err=%0b exp thread=6 err=1", bus.thread_num, bus.err);
        end
        RST = 1'b1;
        #1;
        checks++;
        if (bus.start !== 1'b0 || bus.ts_wr_en !== 1'b0) begin
            errors++;
            $display("FAIL mid_strobes start=%0b ts_wr_en=%0b exp 0 0", bus.start, bus.ts_wr_en);
        end
        checks++;
        if (bus.thread_num !== '0 || bus.core_num !== '0) begin
            errors++;
            $display("FAIL mid_grant thread=%0d core=%0d exp 0 0", bus.thread_num, bus.core_num);
        end
        checks++;
        if (bus.err !== 1'b0 || bus.ts_rd_num !== '0) begin
            errors++;
            $display("FAIL mid_state err=%0b ts_rd_num=%0d exp 0 0", bus.err, bus.ts_rd_num);
        end
        step();
    endtask

`ifdef THREAD_SCHED_TIMEOUT_EN
    task automatic test_timeout();
        int s;
        int k;
        reset_dut();
        bus.core_ready = 4'b1111;
        set_state(7, TS_WR_RDY);
        exp_q.push_back('{thread_num: 4'd7, core_num: 2'd0});
        release_rst();
        wait_starts(1, 30, "wd_start");
        s = start_cyc;
        k = 0;
        while (bus.err !== 1'b1 && k < int'(TB_TIMEOUT) + 10) begin
            step();
            k++;
        end
        checks++;
        if (cyc != s + int'(TB_TIMEOUT) + 1) begin
            errors++;
            $display("FAIL wd_time err_after=%0d exp=%0d", cyc - s, TB_TIMEOUT + 1);
        end
        checks++;
        if (bus.ts_rd_num !== 4'd8) begin errors++; $display("FAIL wd_resume ts_rd_num=%0d exp=8", bus.ts_rd_num); end
    endtask
`endif

    initial begin
        #2_000_000;
        $display("FAIL global_timeout cycles=%0d", cyc);
        $fatal(1, "bench did not finish");
    end

    initial begin
        RST = 1'b1;
        bus.core_ready = '0;
        bus.done = 1'b0;
        cpu_we = 1'b0;
        cpu_clr = 1'b0;
        cpu_num = '0;
        cpu_val = '0;
        test_reset();
        test_idle_scan();
        test_single_grant();
        test_two_grants();
        test_core_busy();
        test_retry();
        test_err();
        test_reset_mid();
`ifdef THREAD_SCHED_TIMEOUT_EN
        test_timeout();
`endif
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_leftover pending=%0d exp=0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
